// File: rtl/chan_pulse_pkg.sv
// Shared types and default widths for the channel pulse generator.
package chan_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_t;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_REP_W = 8;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_pulse_ch.sv
// One pulse channel: high/low phase down-counter plus remaining-pulse down-counter.
//  state   | meaning
//  ST_IDLE | output low, waiting for a start
//  ST_HIGH | output high, r_cnt cycles left after this one
//  ST_LOW  | output low, r_cnt cycles left after this one
module chan_pulse_ch
  import chan_pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_high,
  input  logic [CNT_W-1:0] i_low,
  input  logic [REP_W-1:0] i_rep,
  input  logic             i_abort,
  output logic             o_dout,
  output logic             o_busy,
  output logic             o_done
);

  ch_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_ld;
  logic [CNT_W-1:0] r_low_ld;
  logic [REP_W-1:0] r_rep_left;
  logic             r_inf;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_high_ld;
  logic [CNT_W-1:0] w_low_ld;

  // A zero length behaves as a one-cycle phase, so both load a count of 0.
  assign w_high_ld = (i_high == '0) ? '0 : i_high - CNT_W'(1);
  assign w_low_ld  = (i_low  == '0) ? '0 : i_low  - CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_high_ld  <= '0;
      r_low_ld   <= '0;
      r_rep_left <= '0;
      r_inf      <= 1'b0;
      r_dout     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= ST_IDLE;
        r_dout  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state    <= ST_HIGH;
              r_cnt      <= w_high_ld;
              r_high_ld  <= w_high_ld;
              r_low_ld   <= w_low_ld;
              r_rep_left <= i_rep - REP_W'(1);
              r_inf      <= (i_rep == '0);
              r_dout     <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          ST_HIGH: begin
            if (r_cnt == '0) begin
              r_state <= ST_LOW;
              r_cnt   <= r_low_ld;
              r_dout  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else if (r_inf || (r_rep_left != '0)) begin
              r_state <= ST_HIGH;
              r_cnt   <= r_high_ld;
              r_dout  <= 1'b1;
              if (!r_inf) r_rep_left <= r_rep_left - REP_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dout = r_dout;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/chan_pulse_gen.sv
// N-channel pulse generator: command/abort decode and cmd_ready mux around
// independent per-channel sequencers.
module chan_pulse_gen
  import chan_pulse_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int REP_W = DEF_REP_W,
  localparam int CH_W  = ch_idx_w(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CH_W-1:0]  i_cmd_ch,
  input  logic [CNT_W-1:0] i_cmd_high,
  input  logic [CNT_W-1:0] i_cmd_low,
  input  logic [REP_W-1:0] i_cmd_rep,
  input  logic             i_abort,
  input  logic [CH_W-1:0]  i_abort_ch,
  output logic [N_CH-1:0]  o_dout,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_done,
  output logic             o_cmd_err
);

  logic            w_cmd_in_range;
  logic            w_busy_sel;
  logic            w_abort_same;
  logic            w_accept;
  logic [N_CH-1:0] w_start;
  logic [N_CH-1:0] w_abort_vec;
  logic            r_cmd_err;

  assign w_cmd_in_range = ({{(32-CH_W){1'b0}}, i_cmd_ch} < 32'(N_CH));

  always_comb begin
    w_busy_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (i_cmd_ch == CH_W'(i)) w_busy_sel = o_busy[i];
    end
  end

  // An abort aimed at the commanded channel blocks the command that cycle.
  assign w_abort_same = i_abort && (i_abort_ch == i_cmd_ch);
  assign o_cmd_ready  = w_cmd_in_range ? (!w_busy_sel && !w_abort_same) : 1'b1;
  assign w_accept     = i_cmd_valid && o_cmd_ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_start[gi]     = w_accept && (i_cmd_ch == CH_W'(gi));
    assign w_abort_vec[gi] = i_abort && (i_abort_ch == CH_W'(gi));

    chan_pulse_ch #(
      .CNT_W(CNT_W),
      .REP_W(REP_W)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_start(w_start[gi]),
      .i_high (i_cmd_high),
      .i_low  (i_cmd_low),
      .i_rep  (i_cmd_rep),
      .i_abort(w_abort_vec[gi]),
      .o_dout (o_dout[gi]),
      .o_busy (o_busy[gi]),
      .o_done (o_done[gi])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cmd_err <= 1'b0;
    else          r_cmd_err <= w_accept && !w_cmd_in_range;
  end

  assign o_cmd_err = r_cmd_err;

endmodule
